serial_link_scheduler: RTL and testbench
========================================

Name: serial_link_scheduler

Overview:
- Sequences the shared serial core for N hashing cores.
- TX side: latches found nonces from N requesters, arbitrates round-robin, and feeds one 32-bit word at a time into the serial core's tx_ready/word/tx_busy handshake.
- RX side: counts received byte strobes, issues a one-cycle new_job pulse after every 64-byte work frame (midstate+data2), and resynchronises on idle timeout.
- Sits between the serial core and the hasher array.

Parameters:
- NUM_REQ, 4, number of nonce requesters (1..8).
- FRAME_BYTES, 64, received bytes per work frame.
- RX_TIMEOUT, 2500000, idle clocks after which a partial frame is discarded (100 ms at 25 MHz).
- TX_START_WAIT, 4, clocks to wait for tx_busy to rise after a tx_ready pulse before flagging an error.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_ready  input  1  byte-received strobe from serial core, one cycle per byte.
- tx_busy  input  1  serial core transmit busy.
- tx_ready  output  1  one-cycle start pulse to serial core.
- word  output  32  nonce to transmit; valid while tx_ready=1.
- req_valid  input  NUM_REQ  per-requester nonce-found strobe.
- req_nonce  input  32*NUM_REQ  nonces; requester i at [32*i+31:32*i].
- req_pending  output  NUM_REQ  holding register i occupied.
- new_job  output  1  one-cycle pulse when a full frame has been received.
- rx_byte_count  output  $clog2(FRAME_BYTES+1)  bytes of the current frame received so far.
- overflow_count  output  8  saturating count of nonces dropped on full holding registers.
- tx_error  output  1  sticky flag: tx_busy failed to rise within TX_START_WAIT.

Behaviour:
- Reset (async assert, sync release): tx_ready=0, word=0, req_pending=0, new_job=0, rx_byte_count=0, overflow_count=0, tx_error=0, rr pointer=0, FSM=IDLE.
- Holding registers:
  - One entry per requester.
  - req_valid[i] with pending[i]=0: capture nonce, pending[i]<=1 next cycle.
  - req_valid[i] with pending[i]=1 and not being granted this cycle: nonce dropped, overflow_count+1, saturating at 255.
  - Capture in the same cycle as grant-clear of i: the new nonce is kept and pending stays 1.
- Arbiter:
  - Round-robin starting at the rr pointer.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
- TX FSM:
  - IDLE: if any pending bit is set and tx_busy=0, select winner g, word<=nonce[g], clear pending[g], go to LOAD.
  - LOAD: tx_ready=1 for exactly one cycle with word stable; go to WAIT_START and clear the timer.
  - WAIT_START: on tx_busy=1 go to WAIT_DONE. If the timer reaches TX_START_WAIT, set tx_error and return to IDLE; the nonce is lost.
  - WAIT_DONE: when tx_busy=0, return to IDLE.
  - word holds its value until the next LOAD.
  - Minimum spacing between tx_ready pulses is one full serial-core word (tx_busy low observed).
- RX framing:
  - Each rx_ready increments rx_byte_count and clears the idle timer.
  - When a strobe brings the count to FRAME_BYTES: count<=0 and new_job=1 on the next cycle, for one cycle.
  - Idle timer counts only while rx_byte_count≠0. On reaching RX_TIMEOUT: count<=0, no new_job.
  - A strobe in the same cycle as timeout: the strobe wins and the count becomes 1 if the count was 0 after discard. Specifically, timeout clears first, then the strobe is counted, giving count=1.
- Reset mid-transfer: FSM returns to IDLE immediately. Any tx_ready pulse in flight is cut; the serial core may still finish the word.

Optional Feature:
- Macro STALE_NONCE_FLUSH_EN.
- Defined: the new_job pulse clears all req_pending bits in the same cycle, and a capture in that cycle is also discarded, not counted as overflow. An FSM already past IDLE completes normally.
- Undefined: pending nonces survive new_job and are transmitted in order.

Test Plan:
- Single request: req_valid[2]=1, nonce 0xDEADBEEF, serial-core model raises tx_busy 1 cycle after tx_ready for 40 cycles -> exactly one tx_ready pulse with word=0xDEADBEEF, req_pending[2] 1→0, FSM back to IDLE after tx_busy falls.
- Round-robin: all four requesters valid at once with nonces 0x10..0x13, rr=0 -> transmit order 0x10, 0x11, 0x12, 0x13. A repeat request on 0 during the sequence is sent after 0x13.
- Overflow: req_valid[1] pulsed twice while pending[1]=1 and TX blocked -> overflow_count=2. Force 300 drops -> saturates at 255.
- Frame: 64 rx_ready strobes spaced 10 cycles apart -> new_job one cycle after the 64th strobe, rx_byte_count=0. 130 strobes -> two new_job pulses, count=2.
- Timeout: 20 strobes then idle RX_TIMEOUT cycles (bench param 100) -> count=0, no new_job. Then 64 strobes -> one new_job.
- Error and flush: hold tx_busy=0 after tx_ready -> tx_error=1 after 4 cycles. With STALE_NONCE_FLUSH_EN, pending bits 0b1010 and new_job -> req_pending=0 next cycle, no tx_ready.

Source files
------------

// File: rtl/serial_link_scheduler.sv
// ============================================================================
//  Module   : serial_link_scheduler
//  Purpose  : Round-robin nonce scheduler and RX work-frame counter for a
//             shared serial core. Optional macro STALE_NONCE_FLUSH_EN drops
//             pending nonces on every new_job pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_link_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int FRAME_BYTES   = 64,
   parameter int RX_TIMEOUT    = 2500000,
   parameter int TX_START_WAIT = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rx_ready,
   input  logic                               tx_busy,
   output logic                               tx_ready,
   output logic [31:0]                        word,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [32*NUM_REQ-1:0]              req_nonce,
   output logic [NUM_REQ-1:0]                 req_pending,
   output logic                               new_job,
   output logic [$clog2(FRAME_BYTES+1)-1:0]   rx_byte_count,
   output logic [7:0]                         overflow_count,
   output logic                               tx_error
);

   localparam int CW = $clog2(FRAME_BYTES + 1);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(RX_TIMEOUT + 1);
   localparam int SW = $clog2(TX_START_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD       = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } state_t;

   state_t                    state_q;
   logic                      tx_ready_q;
   logic [31:0]               word_q;
   logic [IW-1:0]             rr_q;
   logic [SW-1:0]             start_tmr_q;
   logic                      tx_error_q;

   logic [NUM_REQ-1:0]        pending_q, pending_d;
   logic [NUM_REQ-1:0][31:0]  nonce_q, nonce_d;
   logic [7:0]                overflow_q, overflow_d;

   logic [CW-1:0]             rx_cnt_q, rx_cnt_d;
   logic [TW-1:0]             rx_tmr_q, rx_tmr_d;
   logic                      new_job_q, new_job_d;

   logic                      w_flush;
   logic                      w_found;
   logic [IW-1:0]             w_gnt_idx;
   logic [IW:0]               w_idx_x;
   logic                      w_grant;
   logic [NUM_REQ-1:0]        w_gnt_vec;
   logic [IW-1:0]             w_rr_next;
   logic [3:0]                w_drops;
   logic [8:0]                w_ovf_sum;
   logic                      w_rx_timeout;
   logic [CW-1:0]             w_rx_base;
   logic [CW-1:0]             w_rx_inc;

`ifdef STALE_NONCE_FLUSH_EN
   assign w_flush = new_job_q;
`else
   assign w_flush = 1'b0;
`endif

   // First pending requester at or after the round-robin pointer
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_idx_x   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx_x = {1'b0, rr_q} + (IW+1)'(k);
         if (w_idx_x >= (IW+1)'(NUM_REQ)) begin
            w_idx_x = w_idx_x - (IW+1)'(NUM_REQ);
         end
         if (!w_found && pending_q[w_idx_x[IW-1:0]]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx_x[IW-1:0];
         end
      end
   end

   assign w_grant   = (state_q == ST_IDLE) && w_found && !tx_busy && !w_flush;
   assign w_gnt_vec = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
   assign w_rr_next = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IW'(1));

   // Holding registers: a capture on the grant cycle refills the slot
   always_comb begin
      pending_d = pending_q;
      nonce_d   = nonce_q;
      w_drops   = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_flush) begin
            pending_d[i] = 1'b0;
         end else if (req_valid[i] && (!pending_q[i] || w_gnt_vec[i])) begin
            pending_d[i] = 1'b1;
            nonce_d[i]   = req_nonce[32*i +: 32];
         end else if (req_valid[i]) begin
            w_drops = w_drops + 4'd1;
         end else if (w_gnt_vec[i]) begin
            pending_d[i] = 1'b0;
         end
      end
      w_ovf_sum  = {1'b0, overflow_q} + 9'(w_drops);
      overflow_d = w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         nonce_q    <= '0;
         overflow_q <= 8'd0;
      end else begin
         pending_q  <= pending_d;
         nonce_q    <= nonce_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tx_ready_q  <= 1'b0;
         word_q      <= 32'd0;
         rr_q        <= '0;
         start_tmr_q <= '0;
         tx_error_q  <= 1'b0;
      end else begin
         tx_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_grant) begin
                  word_q     <= nonce_q[w_gnt_idx];
                  rr_q       <= w_rr_next;
                  tx_ready_q <= 1'b1;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               start_tmr_q <= '0;
               state_q     <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (tx_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (start_tmr_q == SW'(TX_START_WAIT - 1)) begin
                  tx_error_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  start_tmr_q <= start_tmr_q + SW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A timeout coinciding with a strobe discards first, then counts the strobe
   always_comb begin
      w_rx_timeout = (rx_cnt_q != '0) && (rx_tmr_q == TW'(RX_TIMEOUT - 1));
      w_rx_base    = w_rx_timeout ? '0 : rx_cnt_q;
      w_rx_inc     = w_rx_base + CW'(1);
      rx_cnt_d     = rx_cnt_q;
      rx_tmr_d     = rx_tmr_q;
      new_job_d    = 1'b0;
      if (rx_ready) begin
         rx_tmr_d = '0;
         if (w_rx_inc == CW'(FRAME_BYTES)) begin
            rx_cnt_d  = '0;
            new_job_d = 1'b1;
         end else begin
            rx_cnt_d = w_rx_inc;
         end
      end else if (w_rx_timeout) begin
         rx_cnt_d = '0;
         rx_tmr_d = '0;
      end else if (rx_cnt_q != '0) begin
         rx_tmr_d = rx_tmr_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_q  <= '0;
         rx_tmr_q  <= '0;
         new_job_q <= 1'b0;
      end else begin
         rx_cnt_q  <= rx_cnt_d;
         rx_tmr_q  <= rx_tmr_d;
         new_job_q <= new_job_d;
      end
   end

   assign tx_ready       = tx_ready_q;
   assign word           = word_q;
   assign req_pending    = pending_q;
   assign new_job        = new_job_q;
   assign rx_byte_count  = rx_cnt_q;
   assign overflow_count = overflow_q;
   assign tx_error       = tx_error_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_link_scheduler.sv
// ============================================================================
//  Module   : tb_serial_link_scheduler
//  Purpose  : Scoreboard bench for serial_link_scheduler (directed vectors).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_link_scheduler;

   localparam int NR       = 4;
   localparam int FB       = 64;
   localparam int RXT      = 100;
   localparam int TSW      = 4;
   localparam int BUSY_LEN = 40;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_ready = 1'b0;
   logic              model_busy = 1'b0;
   logic              block_busy = 1'b0;
   logic              model_en = 1'b1;
   logic              tx_busy;
   logic              tx_ready;
   logic [31:0]       word;
   logic [NR-1:0]     req_valid = '0;
   logic [32*NR-1:0]  req_nonce = '0;
   logic [NR-1:0]     req_pending;
   logic              new_job;
   logic [6:0]        rx_byte_count;
   logic [7:0]        overflow_count;
   logic              tx_error;

   int                tests = 0;
   int                fails = 0;
   int                tx_count = 0;
   int                nj_count = 0;
   logic [31:0]       exp_q[$];

   assign tx_busy = model_busy | block_busy;

   serial_link_scheduler #(
      .NUM_REQ       (NR),
      .FRAME_BYTES   (FB),
      .RX_TIMEOUT    (RXT),
      .TX_START_WAIT (TSW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_ready       (rx_ready),
      .tx_busy        (tx_busy),
      .tx_ready       (tx_ready),
      .word           (word),
      .req_valid      (req_valid),
      .req_nonce      (req_nonce),
      .req_pending    (req_pending),
      .new_job        (new_job),
      .rx_byte_count  (rx_byte_count),
      .overflow_count (overflow_count),
      .tx_error       (tx_error)
   );

   always #5 clk = ~clk;

   // Serial core: busy rises the cycle after a start pulse and lasts BUSY_LEN clocks
   always @(posedge clk) begin
      if (rst_n && tx_ready && model_en) begin
         model_busy <= 1'b1;
         repeat (BUSY_LEN) @(posedge clk);
         model_busy <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (new_job) nj_count++;
            if (tx_ready) begin
               tx_count++;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL tx_unexpected: word 0x%0h sent, nothing expected", word);
               end else begin
                  check("tx_word", word, exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_req(input int i, input logic [31:0] n);
      @(negedge clk);
      req_nonce[32*i +: 32] = n;
      req_valid[i] = 1'b1;
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic strobes(input int n, input int gap);
      repeat (n) begin
         @(negedge clk);
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || tx_busy || tx_ready) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      check({name, "_drain_timeout"}, 32'(c >= 3000), 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base_tx;
      int base_nj;
      int c;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_word", word, 32'd0);
      check("rst_pending", 32'(req_pending), 32'd0);
      check("rst_new_job", 32'(new_job), 32'd0);
      check("rst_rx_count", 32'(rx_byte_count), 32'd0);
      check("rst_overflow", 32'(overflow_count), 32'd0);
      check("rst_tx_error", 32'(tx_error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request
      base_tx = tx_count;
      exp_q.push_back(32'hDEADBEEF);
      pulse_req(2, 32'hDEADBEEF);
      check("single_pending_set", 32'(req_pending), 32'h4);
      wait_idle("single");
      check("single_pending_clr", 32'(req_pending), 32'h0);
      check("single_tx_count", 32'(tx_count - base_tx), 32'd1);
      check("single_no_error", 32'(tx_error), 32'd0);

      // Round-robin from pointer 0, plus a repeat request on 0
      do_reset();
      base_tx = tx_count;
      @(negedge clk);
      req_nonce = {32'h13, 32'h12, 32'h11, 32'h10};
      req_valid = 4'hF;
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h11);
      exp_q.push_back(32'h12);
      exp_q.push_back(32'h13);
      @(negedge clk);
      req_valid = 4'h0;
      c = 0;
      while (tx_count == base_tx && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("rr_first_timeout", 32'(c >= 100), 32'd0);
      exp_q.push_back(32'h20);
      pulse_req(0, 32'h20);
      wait_idle("rr");
      check("rr_tx_count", 32'(tx_count - base_tx), 32'd5);
      check("rr_overflow", 32'(overflow_count), 32'd0);

      // Overflow and saturation with TX blocked
      do_reset();
      base_tx = tx_count;
      @(negedge clk);
      block_busy = 1'b1;
      exp_q.push_back(32'hA5A50001);
      pulse_req(1, 32'hA5A50001);
      pulse_req(1, 32'hBAD00001);
      pulse_req(1, 32'hBAD00002);
      check("ovf_two", 32'(overflow_count), 32'd2);
      check("ovf_pending", 32'(req_pending), 32'h2);
      @(negedge clk);
      req_nonce[63:32] = 32'hBAD00003;
      req_valid[1] = 1'b1;
      repeat (300) @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("ovf_saturate", 32'(overflow_count), 32'd255);
      block_busy = 1'b0;
      wait_idle("ovf");
      check("ovf_tx_count", 32'(tx_count - base_tx), 32'd1);

      // Frame counting
      do_reset();
      base_nj = nj_count;
      strobes(63, 10);
      check("frame_cnt_63", 32'(rx_byte_count), 32'd63);
      check("frame_no_job_yet", 32'(nj_count - base_nj), 32'd0);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("frame_new_job_pulse", 32'(new_job), 32'd1);
      check("frame_cnt_wrap", 32'(rx_byte_count), 32'd0);
      @(negedge clk);
      check("frame_new_job_one_cycle", 32'(new_job), 32'd0);
      strobes(130, 10);
      check("frame_130_jobs", 32'(nj_count - base_nj), 32'd3);
      check("frame_130_cnt", 32'(rx_byte_count), 32'd2);

      // Idle timeout discards a partial frame
      do_reset();
      base_nj = nj_count;
      strobes(20, 10);
      check("to_cnt_20", 32'(rx_byte_count), 32'd20);
      repeat (RXT + 10) @(negedge clk);
      check("to_cnt_cleared", 32'(rx_byte_count), 32'd0);
      check("to_no_job", 32'(nj_count - base_nj), 32'd0);
      strobes(64, 10);
      check("to_full_frame_job", 32'(nj_count - base_nj), 32'd1);
      check("to_full_frame_cnt", 32'(rx_byte_count), 32'd0);

      // tx_busy never rises -> sticky error
      do_reset();
      base_tx = tx_count;
      model_en = 1'b0;
      exp_q.push_back(32'h55AA55AA);
      pulse_req(3, 32'h55AA55AA);
      c = 0;
      while (!tx_error && c < 30) begin
         @(negedge clk);
         c++;
      end
      check("err_tx_error", 32'(tx_error), 32'd1);
      check("err_pending", 32'(req_pending), 32'h0);
      check("err_tx_count", 32'(tx_count - base_tx), 32'd1);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(tx_error), 32'd1);
      model_en = 1'b1;

      // Pending nonces around a new_job pulse
      do_reset();
      base_tx = tx_count;
      @(negedge clk);
      block_busy = 1'b1;
      pulse_req(1, 32'h00000111);
      pulse_req(3, 32'h00000333);
      check("flush_pending_before", 32'(req_pending), 32'hA);
      strobes(64, 2);
`ifdef STALE_NONCE_FLUSH_EN
      check("flush_pending_after", 32'(req_pending), 32'h0);
      block_busy = 1'b0;
      repeat (20) @(negedge clk);
      check("flush_no_tx", 32'(tx_count - base_tx), 32'd0);
`else
      check("flush_pending_after", 32'(req_pending), 32'hA);
      exp_q.push_back(32'h00000111);
      exp_q.push_back(32'h00000333);
      block_busy = 1'b0;
      wait_idle("keep");
      check("keep_tx_count", 32'(tx_count - base_tx), 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
